// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - byte-frame constants, states and helpers shared by the UART framer and parser
//   START_BYTE/STOP_BYTE  frame delimiters
//   MODE_*                operation codes in mode[3:0]
//   frame_state_t         byte slot currently being handled
//   frame_phase_t         SEND (request byte) / WAIT (byte on the wire)
//   data_len()            number of data bytes carried by a frame (0..2)
package uart_frame_pkg;

  localparam logic [7:0] START_BYTE = 8'hFF;
  localparam logic [7:0] STOP_BYTE  = 8'hFF;

  localparam logic [3:0] MODE_RD1 = 4'b0001;
  localparam logic [3:0] MODE_RD2 = 4'b0010;
  localparam logic [3:0] MODE_WR1 = 4'b0100;
  localparam logic [3:0] MODE_WR2 = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_STATUS,
    ST_DATA1,
    ST_DATA2,
    ST_STOP
  } frame_state_t;

  typedef enum logic {
    PH_SEND,
    PH_WAIT
  } frame_phase_t;

  // A NACKed transaction carries no data, whatever the operation was.
  function automatic logic [1:0] data_len(input logic [7:0] mode, input logic nack);
    logic [1:0] len;
    len = 2'd0;
    if (!nack) begin
      case (mode[3:0])
        MODE_RD1: len = 2'd1;
        MODE_RD2: len = 2'd2;
        MODE_WR1, MODE_WR2: len = 2'd0;
        default: len = 2'd0;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/timeout_timer.sv
// rtl/timeout_timer.sv - 32-bit watchdog counter with a terminal-count pulse after MAX enabled cycles
//   clk, reset   clock, asynchronous active-high reset
//   clear        restart counting from zero
//   enable       count this cycle
//   tc           high on the MAX-th consecutive enabled cycle after a clear
module timeout_timer #(
  parameter int unsigned MAX = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [31:0] LAST = 32'(MAX - 1);

  logic [31:0] count;

  assign tc = enable && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tc) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/i2c_uart_response_framer.sv
// rtl/i2c_uart_response_framer.sv - serialises I2C response-queue entries into UART byte frames
//   rsp_valid/rsp_addr/rsp_mode/rsp_data/rsp_nack  head of the response queue
//   rsp_rd        one-cycle pop of the response queue
//   tx_ready/tx_done_tick  UART TX core status
//   tx_start/tx_byte       one-cycle byte request to the UART TX core
//   busy          frame in progress
//   tx_timeout    one-cycle pulse when a frame is abandoned
// Frame: FF, ADDR, {nack, mode[6:0]}, [data[7:0]], [data[15:8]], FF
module i2c_uart_response_framer
  import uart_frame_pkg::*;
#(
  parameter int unsigned SYS_FREQ   = 100_000_000,
  parameter int unsigned TIMEOUT_MS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_addr,
  input  logic [7:0]  rsp_mode,
  input  logic [15:0] rsp_data,
  input  logic        rsp_nack,
  output logic        rsp_rd,
  input  logic        tx_ready,
  input  logic        tx_done_tick,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        tx_timeout
);

  localparam longint unsigned MAX_WAIT_WIDE = 64'(SYS_FREQ / 1000) * 64'(TIMEOUT_MS);
  localparam int unsigned     MAX_WAIT      = 32'(MAX_WAIT_WIDE);

  generate
    if (MAX_WAIT_WIDE > 64'h0000_0000_FFFF_FFFF || MAX_WAIT_WIDE == 64'd0) begin : g_bad_max_wait
      $error("MAX_WAIT must lie in 1 .. 2**32-1 cycles");
    end
  endgenerate

  frame_state_t state, state_n, state_after;
  frame_phase_t phase, phase_n;

  logic [7:0]  addr_q;
  logic [7:0]  mode_q;
  logic [15:0] data_q;
  logic        nack_q;
  logic [1:0]  len;
  logic        tmr_en;
  logic        tmr_tc;

  assign len      = data_len(mode_q, nack_q);
  assign busy     = (state != ST_IDLE);
  assign rsp_rd   = !busy && rsp_valid;
  assign tx_start = busy && (phase == PH_SEND) && tx_ready;
  // A done tick on the terminal-count cycle must win, so it also stops the count.
  assign tmr_en     = busy && (phase == PH_WAIT) && !tx_done_tick;
  assign tx_timeout = tmr_tc;

  timeout_timer #(
    .MAX(MAX_WAIT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (tx_start),
    .enable(tmr_en),
    .tc    (tmr_tc)
  );

  // Byte for the current slot; held through WAIT because it depends only on state.
  always_comb begin
    tx_byte = 8'h00;
    case (state)
      ST_START:  tx_byte = START_BYTE;
      ST_ADDR:   tx_byte = addr_q;
      ST_STATUS: tx_byte = {nack_q, mode_q[6:0]};
      ST_DATA1:  tx_byte = data_q[7:0];
      ST_DATA2:  tx_byte = data_q[15:8];
      ST_STOP:   tx_byte = STOP_BYTE;
      default:   tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_after = ST_IDLE;
    case (state)
      ST_START:  state_after = ST_ADDR;
      ST_ADDR:   state_after = ST_STATUS;
      ST_STATUS: state_after = (len != 2'd0) ? ST_DATA1 : ST_STOP;
      ST_DATA1:  state_after = (len == 2'd2) ? ST_DATA2 : ST_STOP;
      ST_DATA2:  state_after = ST_STOP;
      default:   state_after = ST_IDLE;
    endcase
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    if (!busy) begin
      phase_n = PH_SEND;
      if (rsp_valid) begin
        state_n = ST_START;
      end
    end else if (phase == PH_SEND) begin
      if (tx_ready) begin
        phase_n = PH_WAIT;
      end
    end else if (tx_done_tick) begin
      state_n = state_after;
      phase_n = PH_SEND;
    end else if (tmr_tc) begin
      state_n = ST_IDLE;
      phase_n = PH_SEND;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      phase  <= PH_SEND;
      addr_q <= '0;
      mode_q <= '0;
      data_q <= '0;
      nack_q <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      if (rsp_rd) begin
        addr_q <= rsp_addr;
        mode_q <= rsp_mode;
        data_q <= rsp_data;
        nack_q <= rsp_nack;
      end
    end
  end

endmodule
